// File: rtl/spi_controller.sv
// SPI mode-0 initiator: latches one {rw,addr,wdata} frame per start and shifts it MSB-first
// on copi while capturing cipo; sclk and ncs are generated from clk, all outputs registered.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo
);

  localparam int unsigned HW = $clog2(CLK_DIV + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   half_q, half_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [4:0]      bit_q, bit_d;
  logic            high_q, high_d;
  logic [15:0]     frame_q, frame_d;
  // Only the last 8 cipo samples (frame bits 7:0) are ever observable, so only those are kept.
  logic [7:0]      sin_q, sin_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            sclk_q, sclk_d;
  logic            ncs_q, ncs_d;
  logic            copi_q, copi_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      high_q  <= 1'b0;
      frame_q <= '0;
      sin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      high_q  <= high_d;
      frame_q <= frame_d;
      sin_q   <= sin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    high_d  = high_q;
    frame_d = frame_q;
    sin_d   = sin_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          frame_d = {rw, addr, wdata};
          half_d  = '0;
          gap_d   = '0;
          bit_d   = '0;
          high_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (!high_q) begin
            high_d = 1'b1;
          end else begin
            // End of a high half: sample cipo and move to the next bit.
            high_d = 1'b0;
            sin_d  = {sin_q[6:0], cipo};
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd15) state_d = ST_HOLD;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          state_d = ST_GAP;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that the registered pins line up with it.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    ncs_d   = !((state_d == ST_SHIFT) || (state_d == ST_HOLD));
    sclk_d  = (state_d == ST_SHIFT) && high_d;
    copi_d  = 1'b0;
    if (state_d == ST_SHIFT) copi_d = frame_d[4'd15 - bit_d[3:0]];
    else if (state_d == ST_HOLD) copi_d = copi_q;
    done_d  = (state_q == ST_GAP) && (gap_q == GAP_LAST);
    rdata_d = rdata_q;
    if (done_d && !frame_q[15]) rdata_d = sin_q;
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign ncs   = ncs_q;
  assign copi  = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: per-cycle waveform model derived from the frame timing
// formulas, plus a behavioural register peripheral on the SPI link of the CLK_DIV=4 instance.
module tb_spi_controller;

  localparam int D_A = 4;
  localparam int G_A = 2;
  localparam int T_A = 33 * D_A + G_A + 1;
  localparam int D_B = 1;
  localparam int G_B = 1;
  localparam int T_B = 33 * D_B + G_B + 1;

  logic       clk = 1'b0;
  logic       rst, start_a, start_b, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy_a, done_a, sclk_a, ncs_a, copi_a, cipo_a;
  logic [7:0] rdata_a;
  logic       busy_b, done_b, sclk_b, ncs_b, copi_b;
  logic       cipo_b = 1'b0;
  logic [7:0] rdata_b;

  int checks = 0;
  int errors = 0;

  // Trace bits: 0 ncs, 1 busy, 2 done, 3 sclk, 4 copi.
  logic [4:0] tr [0:299];
  logic [7:0] rdata_tr [0:299];
  logic [7:0] exp_regs [0:127] = '{default: 8'h00};
  logic [7:0] exp_rdata = 8'h00;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D_A), .GAP(G_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .sclk(sclk_a), .ncs(ncs_a),
    .copi(copi_a), .cipo(cipo_a)
  );

  spi_controller #(.CLK_DIV(D_B), .GAP(G_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .sclk(sclk_b), .ncs(ncs_b),
    .copi(copi_b), .cipo(cipo_b)
  );

  // Behavioural register peripheral: samples copi on sclk rise, commits writes on ncs rise
  // after a full 16-bit frame, answers reads on sclk fall once the address byte is in.
  logic [7:0] periph_regs [0:127] = '{default: 8'h00};
  logic [15:0] rx = 16'h0;
  int          rx_cnt = 0;
  logic        p_rw = 1'b1;
  logic [6:0]  p_addr = 7'h0;

  always @(posedge sclk_a or posedge ncs_a) begin
    if (ncs_a === 1'b1) begin
      if (rx_cnt == 16 && p_rw) periph_regs[p_addr] = rx[7:0];
      rx_cnt = 0;
    end else begin
      rx = {rx[14:0], copi_a};
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 8) begin
        p_rw   = rx[7];
        p_addr = rx[6:0];
      end
    end
  end

  always @(negedge sclk_a or posedge ncs_a) begin
    if (ncs_a === 1'b0 && rx_cnt >= 8 && rx_cnt < 16 && !p_rw)
      cipo_a = periph_regs[p_addr][7 - (rx_cnt - 8)];
    else
      cipo_a = 1'b0;
  end

  // Expected value of signal s on cycle n after acceptance (cycle 0), straight from the frame timing.
  function automatic logic exp_sig(int s, int n, int d, int g, logic [15:0] f);
    logic v;
    case (s)
      0: v = (n > 33 * d);
      1: v = (n <= 33 * d + g);
      2: v = (n == 33 * d + g + 1);
      3: v = (n <= 32 * d) && (((n - 1) % (2 * d)) >= d);
      default: v = (n <= 32 * d) ? f[15 - (n - 1) / (2 * d)] : ((n <= 33 * d) ? f[0] : 1'b0);
    endcase
    return v;
  endfunction

  function automatic int wave_bad(int s, int d, int g, logic [15:0] f, int off);
    int bad = 0;
    for (int n = 1; n <= 33 * d + g + 1; n++)
      if (tr[off + n][s] !== exp_sig(s, n, d, g, f)) bad++;
    return bad;
  endfunction

  function automatic string sig_name(int s);
    case (s)
      0: return "ncs";
      1: return "busy";
      2: return "done";
      3: return "sclk";
      default: return "copi";
    endcase
  endfunction

  function automatic logic [15:0] rise_word(int lo, int hi);
    logic [15:0] w = 16'h0;
    for (int n = lo; n <= hi; n++)
      if (tr[n][3] === 1'b1 && tr[n - 1][3] === 1'b0) w = {w[14:0], tr[n][4]};
    return w;
  endfunction

  function automatic int rise_count(int lo, int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++)
      if (tr[n][3] === 1'b1 && tr[n - 1][3] === 1'b0) c++;
    return c;
  endfunction

  function automatic int ones(int s, int lo, int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++)
      if (tr[n][s] === 1'b1) c++;
    return c;
  endfunction

  task automatic drive_frame(input bit inst, input logic r, input logic [6:0] a, input logic [7:0] w,
                             input int ncyc, input int keep_until, input int glitch_at, input int rst_at);
    tr[0]       = inst ? {copi_b, sclk_b, done_b, busy_b, ncs_b} : {copi_a, sclk_a, done_a, busy_a, ncs_a};
    rdata_tr[0] = inst ? rdata_b : rdata_a;
    rw = r;
    addr = a;
    wdata = w;
    if (inst) start_b = 1'b1; else start_a = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      tr[n]       = inst ? {copi_b, sclk_b, done_b, busy_b, ncs_b} : {copi_a, sclk_a, done_a, busy_a, ncs_a};
      rdata_tr[n] = inst ? rdata_b : rdata_a;
      if (n >= keep_until) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (n == glitch_at) begin
        start_a = 1'b1;
        addr = 7'h7f;
        wdata = 8'hff;
      end
      if (n == rst_at) rst = 1'b1;
      else if (n == rst_at + 1) rst = 1'b0;
    end
  endtask

  task automatic check_wave(input string tag, input int d, input int g, input logic [15:0] f, input int off);
    int b;
    for (int s = 0; s < 5; s++) begin
      checks++;
      b = wave_bad(s, d, g, f, off);
      if (b !== 0) begin
        errors++;
        $display("FAIL %s_%s_wave: %0d cycles differ, expected 0 for frame %h", tag, sig_name(s), b, f);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, rdata_a, sclk_a, ncs_a, copi_a} !== 13'b0_0_00000000_0_1_0) begin
      errors++;
      $display("FAIL reset_a: got %b expected %b", {busy_a, done_a, rdata_a, sclk_a, ncs_a, copi_a}, 13'b0_0_00000000_0_1_0);
    end
    checks++;
    if ({busy_b, done_b, rdata_b, sclk_b, ncs_b, copi_b} !== 13'b0_0_00000000_0_1_0) begin
      errors++;
      $display("FAIL reset_b: got %b expected %b", {busy_b, done_b, rdata_b, sclk_b, ncs_b, copi_b}, 13'b0_0_00000000_0_1_0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy_a, ncs_a, sclk_a} !== 3'b010) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 010", {busy_a, ncs_a, sclk_a});
    end
  endtask

  task automatic test_write();
    drive_frame(1'b0, 1'b1, 7'h04, 8'h80, T_A + 3, 1, 0, 0);
    exp_regs[4] = 8'h80;
    check_wave("write", D_A, G_A, 16'h8480, 0);
    checks++;
    if (rise_word(1, T_A) !== 16'h8480) begin
      errors++;
      $display("FAIL write_copi: got %h expected 8480", rise_word(1, T_A));
    end
    checks++;
    if (rise_count(1, T_A + 3) !== 16) begin
      errors++;
      $display("FAIL write_edges: got %0d expected 16", rise_count(1, T_A + 3));
    end
    checks++;
    if (periph_regs[4] !== exp_regs[4]) begin
      errors++;
      $display("FAIL write_periph: got %h expected %h", periph_regs[4], exp_regs[4]);
    end
  endtask

  task automatic test_read();
    logic [7:0] w;
    drive_frame(1'b0, 1'b1, 7'h01, 8'ha5, T_A + 3, 1, 0, 0);
    exp_regs[1] = 8'ha5;
    w = 8'($urandom);
    drive_frame(1'b0, 1'b0, 7'h01, w, T_A + 3, 1, 0, 0);
    check_wave("read", D_A, G_A, {1'b0, 7'h01, w}, 0);
    checks++;
    if (rise_word(1, T_A) !== {1'b0, 7'h01, w}) begin
      errors++;
      $display("FAIL read_copi: got %h expected %h", rise_word(1, T_A), {1'b0, 7'h01, w});
    end
    checks++;
    if (rdata_tr[T_A - 1] !== exp_rdata || rdata_tr[T_A] !== exp_regs[1]) begin
      errors++;
      $display("FAIL read_rdata: got %h/%h expected %h/%h", rdata_tr[T_A - 1], rdata_tr[T_A], exp_rdata, exp_regs[1]);
    end
    exp_rdata = exp_regs[1];
    w = 8'($urandom);
    drive_frame(1'b0, 1'b1, 7'h02, w, T_A + 3, 1, 0, 0);
    exp_regs[2] = w;
    checks++;
    if (rdata_tr[T_A] !== exp_rdata) begin
      errors++;
      $display("FAIL write_keeps_rdata: got %h expected %h", rdata_tr[T_A], exp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'($urandom_range(1, 255));
    drive_frame(1'b0, 1'b1, 7'h05, w, 60, 1, 0, 40);
    exp_rdata = 8'h00;
    checks++;
    if (tr[41] !== 5'b00001 || rdata_tr[41] !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b/%h expected 00001/00", tr[41], rdata_tr[41]);
    end
    checks++;
    if (ones(2, 1, 60) !== 0) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d pulses expected 0", ones(2, 1, 60));
    end
    checks++;
    if (periph_regs[5] !== exp_regs[5]) begin
      errors++;
      $display("FAIL reset_mid_periph: got %h expected %h", periph_regs[5], exp_regs[5]);
    end
    drive_frame(1'b0, 1'b1, 7'h05, w, T_A + 3, 1, 0, 0);
    exp_regs[5] = w;
    check_wave("after_reset", D_A, G_A, {1'b1, 7'h05, w}, 0);
    checks++;
    if (rise_count(1, T_A + 3) !== 16 || periph_regs[5] !== exp_regs[5]) begin
      errors++;
      $display("FAIL after_reset_frame: got %0d edges reg %h expected 16 edges reg %h",
               rise_count(1, T_A + 3), periph_regs[5], exp_regs[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a;
    logic [7:0] w;
    a = 7'($urandom_range(0, 7));
    w = 8'($urandom);
    drive_frame(1'b0, 1'b1, a, w, 2 * T_A + 3, 2 * T_A, 0, 0);
    exp_regs[a] = w;
    check_wave("b2b_first", D_A, G_A, {1'b1, a, w}, 0);
    check_wave("b2b_second", D_A, G_A, {1'b1, a, w}, T_A);
    checks++;
    if ({tr[132][0], tr[133][0], tr[134][0], tr[135][0], tr[136][0]} !== 5'b01110) begin
      errors++;
      $display("FAIL b2b_ncs_gap: got %b expected 01110 over cycles 132..136",
               {tr[132][0], tr[133][0], tr[134][0], tr[135][0], tr[136][0]});
    end
    checks++;
    if (ones(2, 1, 2 * T_A + 3) !== 2 || rise_count(1, 2 * T_A + 3) !== 32) begin
      errors++;
      $display("FAIL b2b_count: got %0d done %0d edges expected 2 done 32 edges",
               ones(2, 1, 2 * T_A + 3), rise_count(1, 2 * T_A + 3));
    end
  endtask

  task automatic test_ignored();
    drive_frame(1'b0, 1'b1, 7'h04, 8'h80, T_A + 40, 1, 10, 0);
    check_wave("ignored", D_A, G_A, 16'h8480, 0);
    checks++;
    if (rise_word(1, T_A) !== 16'h8480) begin
      errors++;
      $display("FAIL ignored_copi: got %h expected 8480", rise_word(1, T_A));
    end
    checks++;
    if (ones(2, 1, T_A + 40) !== 1 || ones(1, T_A, T_A + 40) !== 0) begin
      errors++;
      $display("FAIL ignored_no_second: got %0d done %0d busy cycles expected 1 and 0",
               ones(2, 1, T_A + 40), ones(1, T_A, T_A + 40));
    end
    checks++;
    if (periph_regs[4] !== exp_regs[4]) begin
      errors++;
      $display("FAIL ignored_periph: got %h expected %h", periph_regs[4], exp_regs[4]);
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [6:0] a;
    logic [7:0] w;
    int         b;
    for (int i = 0; i < 8; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 7'($urandom_range(0, 7));
      w = 8'($urandom);
      drive_frame(1'b0, r, a, w, T_A + 3, 1, 0, 0);
      if (r) exp_regs[a] = w;
      else exp_rdata = exp_regs[a];
      b = 0;
      for (int s = 0; s < 5; s++) b += wave_bad(s, D_A, G_A, {r, a, w}, 0);
      checks++;
      if (b !== 0 || rise_word(1, T_A) !== {r, a, w}) begin
        errors++;
        $display("FAIL rand_frame%0d: %0d bad cycles copi %h expected 0 and %h", i, b, rise_word(1, T_A), {r, a, w});
      end
      checks++;
      if (rdata_tr[T_A] !== exp_rdata || periph_regs[a] !== exp_regs[a]) begin
        errors++;
        $display("FAIL rand_data%0d: rdata %h reg %h expected %h and %h", i, rdata_tr[T_A], periph_regs[a],
                 exp_rdata, exp_regs[a]);
      end
    end
  endtask

  task automatic test_fast();
    int bad;
    drive_frame(1'b1, 1'b1, 7'h03, 8'hc3, T_B + 3, 1, 0, 0);
    check_wave("fast", D_B, G_B, 16'h83c3, 0);
    bad = (tr[1][3] !== 1'b0) ? 1 : 0;
    for (int n = 2; n <= 32; n++)
      if (tr[n][3] === tr[n - 1][3]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fast_toggle: got %0d non-toggling cycles expected 0", bad);
    end
    checks++;
    if (ones(2, 1, T_B + 3) !== 1 || tr[T_B][2] !== 1'b1) begin
      errors++;
      $display("FAIL fast_done: got %0d pulses, cycle35=%b expected 1 and 1", ones(2, 1, T_B + 3), tr[T_B][2]);
    end
    checks++;
    if (rise_word(1, T_B) !== 16'h83c3) begin
      errors++;
      $display("FAIL fast_copi: got %h expected 83c3", rise_word(1, T_B));
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    rw = 1'b0;
    addr = 7'h0;
    wdata = 8'h0;
    test_reset();
    test_write();
    test_read();
    test_reset_mid();
    test_back_to_back();
    test_ignored();
    test_random();
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
